// File: rtl/hamming_serial_tx.sv
// Hamming(7,4) / SECDED(8,4) nibble encoder with a UART-style bit-serial framer.
// A one-entry holding register accepts a second nibble while a frame is in flight.
module hamming_serial_tx #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned EXTENDED     = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          data_in,
    input  logic                start,
    output logic                busy,
    output logic                pending,
    output logic                drop,
    output logic                done,
    output logic [6+EXTENDED:0] code_out,
    output logic                tx
);
    localparam int unsigned   W         = 7 + EXTENDED;
    localparam int unsigned   CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state_q;
    logic [CW-1:0] clk_cnt_q;
    logic [2:0]    bit_idx_q;
    logic          stop_cnt_q;
    logic [W-1:0]  code_q;
    logic [3:0]    hold_q;
    logic          pending_q;
    logic          drop_q;
    logic          done_q;
    logic          tx_q;

    logic          busy_d;
    logic          bit_end_d;
    logic          launch_new_d;
    logic          buffer_d;
    logic          discard_d;
    logic [W-1:0]  new_code_d;
    logic [W-1:0]  hold_code_d;

    function automatic logic [W-1:0] encode(input logic [3:0] d);
        logic [W-1:0] c;
        c    = '0;
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[2] = d[0];
        c[3] = d[1] ^ d[2] ^ d[3];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        if (EXTENDED != 0) c[W-1] = ^c[6:0];
        return c;
    endfunction

    always_comb begin
        busy_d       = (state_q != IDLE) || pending_q;
        bit_end_d    = (clk_cnt_q == CLK_LAST);
        launch_new_d = start && !busy_d;
        buffer_d     = start && busy_d && !pending_q;
        discard_d    = start && pending_q;
        new_code_d   = encode(data_in);
        hold_code_d  = encode(hold_q);
    end

    // Buffering (needs pending=0) and launching from the holding register
    // (needs pending=1) never coincide, so their pending_q writes cannot collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            code_q     <= '0;
            hold_q     <= '0;
            pending_q  <= 1'b0;
            drop_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            drop_q <= discard_d;
            done_q <= 1'b0;
            if (buffer_d) begin
                hold_q    <= data_in;
                pending_q <= 1'b1;
            end
            if (state_q != IDLE) clk_cnt_q <= bit_end_d ? '0 : clk_cnt_q + 1'b1;
            case (state_q)
                IDLE: begin
                    if (pending_q) begin
                        state_q   <= START;
                        code_q    <= hold_code_d;
                        pending_q <= 1'b0;
                        tx_q      <= 1'b0;
                    end else if (launch_new_d) begin
                        state_q <= START;
                        code_q  <= new_code_d;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end_d) begin
                        state_q   <= DATA;
                        bit_idx_q <= '0;
                        tx_q      <= code_q[0];
                    end
                end
                DATA: begin
                    if (bit_end_d) begin
                        if (bit_idx_q == 3'd6) begin
                            bit_idx_q <= '0;
                            if (EXTENDED != 0) begin
                                state_q <= PARITY;
                                tx_q    <= code_q[W-1];
                            end else begin
                                state_q <= STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= code_q[bit_idx_q + 3'd1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end_d) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end_d) begin
                        if (stop_cnt_q == STOP_LAST) begin
                            stop_cnt_q <= 1'b0;
                            done_q     <= 1'b1;
                            if (pending_q) begin
                                state_q   <= START;
                                code_q    <= hold_code_d;
                                pending_q <= 1'b0;
                                tx_q      <= 1'b0;
                            end else begin
                                state_q <= IDLE;
                                code_q  <= '0;
                            end
                        end else begin
                            stop_cnt_q <= stop_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_d;
    assign pending  = pending_q;
    assign drop     = drop_q;
    assign done     = done_q;
    assign code_out = code_q;
    assign tx       = tx_q;
endmodule

// File: tb/tb_hamming_serial_tx.sv
// Scoreboard bench for hamming_serial_tx: three parameterisations share clk, rst and data_in;
// stimulus queues expected codewords, per-instance monitors decode each serial frame.
module tb_hamming_serial_tx;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] data_in;
    logic [2:0] start_v, busy_v, pending_v, drop_v, done_v, tx_v;
    logic [6:0] code0, code2;
    logic [7:0] code1;

    int checks = 0;
    int failures = 0;
    logic [7:0] q0[$], q1[$], q2[$];
    int drop_cnt[3] = '{0, 0, 0};
    int done_cnt[3] = '{0, 0, 0};
    int exp_drop[3] = '{0, 0, 0};
    int exp_done[3] = '{0, 0, 0};

    always #5 clk = ~clk;

    hamming_serial_tx #(.CLKS_PER_BIT(4), .EXTENDED(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .data_in(data_in), .start(start_v[0]),
        .busy(busy_v[0]), .pending(pending_v[0]), .drop(drop_v[0]), .done(done_v[0]),
        .code_out(code0), .tx(tx_v[0]));

    hamming_serial_tx #(.CLKS_PER_BIT(2), .EXTENDED(1), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .data_in(data_in), .start(start_v[1]),
        .busy(busy_v[1]), .pending(pending_v[1]), .drop(drop_v[1]), .done(done_v[1]),
        .code_out(code1), .tx(tx_v[1]));

    hamming_serial_tx #(.CLKS_PER_BIT(1), .EXTENDED(0), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .data_in(data_in), .start(start_v[2]),
        .busy(busy_v[2]), .pending(pending_v[2]), .drop(drop_v[2]), .done(done_v[2]),
        .code_out(code2), .tx(tx_v[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] code_of(input int k);
        case (k)
            0:       return {1'b0, code0};
            1:       return code1;
            default: return {1'b0, code2};
        endcase
    endfunction

    function automatic void push_exp(input int k, input logic [7:0] e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic pop_exp(input int k, output logic [7:0] e, output bit ok);
        e  = '0;
        ok = 1'b0;
        if (qsize(k) > 0) begin
            ok = 1'b1;
            case (k)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] c, input int b, input int w);
        if (b == 0) return 1'b0;
        if (b <= w) return c[b-1];
        return 1'b1;
    endfunction

    // Frame begins at the first low tx sample; a low sample right after done starts a chained frame.
    task automatic monitor(input int k, input int cpb, input int nb, input int w);
        logic [7:0] e;
        bit ok;
        bit aborted;
        forever begin
            @(negedge clk);
            aborted = 1'b0;
            while (!rst && !tx_v[k] && !aborted) begin
                pop_exp(k, e, ok);
                check($sformatf("u%0d frame expected", k), 32'(ok), 32'd1);
                check($sformatf("u%0d code_out", k), 32'(code_of(k)), 32'(e));
                for (int c = 0; c < nb * cpb; c++) begin
                    if (c > 0) @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    check($sformatf("u%0d tx bit %0d", k, c / cpb), 32'(tx_v[k]),
                          32'(exp_bit(e, c / cpb, w)));
                end
                if (!aborted) begin
                    @(negedge clk);
                    check($sformatf("u%0d done", k), 32'(done_v[k]), 32'd1);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (drop_v[i]) drop_cnt[i]++;
            if (done_v[i]) done_cnt[i]++;
        end
    end

    task automatic pulse(input int k, input logic [3:0] d);
        start_v[k] = 1'b1;
        data_in    = d;
        @(posedge clk);
        #1;
        start_v[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] d_tab[3];
        logic [7:0] c_tab[3];
        d_tab = '{4'd8, 4'd15, 4'd0};
        c_tab = '{8'h4B, 8'hFF, 8'h00};

        rst     = 1'b0;
        start_v = '0;
        data_in = '0;
        fork
            monitor(0, 4, 9, 7);
            monitor(1, 2, 10, 8);
            monitor(2, 1, 10, 7);
        join_none

        #3 rst = 1'b1;
        #1;
        check("reset tx", 32'(tx_v), 32'h7);
        check("reset busy", 32'(busy_v), 32'h0);
        check("reset pending", 32'(pending_v), 32'h0);
        check("reset drop", 32'(drop_v), 32'h0);
        check("reset done", 32'(done_v), 32'h0);
        check("reset code", {code1, 1'b0, code0, 1'b0, code2, 8'h00}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single frame, nibble 5
        push_exp(0, 8'h2D);
        pulse(0, 4'd5);
        check("A busy after launch", 32'(busy_v[0]), 32'd1);
        repeat (36) @(posedge clk);
        #1;
        check("A busy after frame", 32'(busy_v[0]), 32'd0);
        exp_done[0]++;

        // Chained frames plus a discarded third request; nibble 9 encodes to 7'h4C
        push_exp(0, 8'h2D);
        pulse(0, 4'd5);
        repeat (4) @(posedge clk);
        #1;
        push_exp(0, 8'h4C);
        pulse(0, 4'd9);
        check("B pending set", 32'(pending_v[0]), 32'd1);
        pulse(0, 4'd1);
        exp_drop[0]++;
        check("B drop pulse", 32'(drop_v[0]), 32'd1);
        check("B pending held", 32'(pending_v[0]), 32'd1);
        repeat (30) @(posedge clk);
        #1;
        check("B pending cleared at chain", 32'(pending_v[0]), 32'd0);
        check("B busy during second", 32'(busy_v[0]), 32'd1);
        repeat (36) @(posedge clk);
        #1;
        check("B busy after both", 32'(busy_v[0]), 32'd0);
        exp_done[0] += 2;

        // Reset during data bit 3 with a buffered nibble; neither may survive
        push_exp(0, 8'h2D);
        pulse(0, 4'd5);
        pulse(0, 4'd9);
        repeat (16) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("C tx on reset", 32'(tx_v[0]), 32'd1);
        check("C busy on reset", 32'(busy_v[0]), 32'd0);
        check("C pending on reset", 32'(pending_v[0]), 32'd0);
        check("C code on reset", 32'(code0), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        push_exp(0, 8'h4B);
        pulse(0, 4'd8);
        repeat (36) @(posedge clk);
        #1;
        check("C busy after clean frame", 32'(busy_v[0]), 32'd0);
        exp_done[0]++;

        // SECDED instance
        for (int i = 0; i < 3; i++) begin
            push_exp(1, c_tab[i]);
            pulse(1, d_tab[i]);
            repeat (20) @(posedge clk);
            #1;
            check($sformatf("D busy after %0d", i), 32'(busy_v[1]), 32'd0);
            exp_done[1]++;
        end

        // Start buffered on the final stop edge: one idle-high cycle, then launch
        push_exp(2, 8'h2D);
        pulse(2, 4'd5);
        repeat (9) @(posedge clk);
        #1;
        push_exp(2, 8'h4B);
        pulse(2, 4'd8);
        check("E pending after late start", 32'(pending_v[2]), 32'd1);
        check("E idle gap tx", 32'(tx_v[2]), 32'd1);
        check("E busy in gap", 32'(busy_v[2]), 32'd1);
        @(posedge clk);
        #1;
        check("E launch tx", 32'(tx_v[2]), 32'd0);
        check("E pending cleared", 32'(pending_v[2]), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check("E busy after", 32'(busy_v[2]), 32'd0);
        exp_done[2] += 2;

        // start held for 12 edges, data_in = edge index: frames 0, 1, 11
        push_exp(2, 8'h00);
        push_exp(2, 8'h07);
        push_exp(2, 8'h55);
        for (int i = 0; i < 12; i++) begin
            start_v[2] = 1'b1;
            data_in    = 4'(i);
            @(posedge clk);
            #1;
        end
        start_v[2] = 1'b0;
        exp_drop[2] += 9;
        repeat (19) @(posedge clk);
        #1;
        check("F busy after", 32'(busy_v[2]), 32'd0);
        exp_done[2] += 3;

        repeat (5) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("u%0d frames outstanding", k), 32'(qsize(k)), 32'd0);
            check($sformatf("u%0d drop count", k), 32'(drop_cnt[k]), 32'(exp_drop[k]));
            check($sformatf("u%0d done count", k), 32'(done_cnt[k]), 32'(exp_done[k]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
